// File: rtl/dmac_regs.sv
// AHB-Lite register file for the DMA controller: config, control/status and IRQ.
// Zero wait states; read data is combinational in the data phase, writes land at data-phase end.
// Never stalls the bus (HREADYOUT tied high); GO/config writes are dropped while the engine is busy.
module dmac_regs (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic [31:0] saddr,
   output logic [31:0] daddr,
   output logic [2:0]  ssize,
   output logic [2:0]  dsize,
   output logic [2:0]  sinc,
   output logic [2:0]  dinc,
   output logic [7:0]  bsize,
   output logic [15:0] bcount,
   output logic        wfi,
   output logic [2:0]  irqsrc,
   output logic [31:0] icra,
   output logic [31:0] icrv,
   output logic        start,
   input  logic        done,
   input  logic        busy,
   output logic        irq
);

   localparam logic [3:0] A_CTRL   = 4'h0;
   localparam logic [3:0] A_STATUS = 4'h1;
   localparam logic [3:0] A_SADDR  = 4'h2;
   localparam logic [3:0] A_DADDR  = 4'h3;
   localparam logic [3:0] A_SIZE   = 4'h4;
   localparam logic [3:0] A_INC    = 4'h5;
   localparam logic [3:0] A_BSIZE  = 4'h6;
   localparam logic [3:0] A_BCOUNT = 4'h7;
   localparam logic [3:0] A_ICRA   = 4'h8;
   localparam logic [3:0] A_ICRV   = 4'h9;

   logic       wr_q;
   logic       rd_q;
   logic [3:0] a;
   logic       ie;
   logic       done_r;
   logic       xfer;
   logic       cfg_we;

   // Only word offsets are decoded and every access is treated as 32-bit.
   logic unused_bits;
   assign unused_bits = ^{HSIZE, HADDR[31:6], HADDR[1:0], HTRANS[0]};

   assign HREADYOUT = 1'b1;
   assign xfer      = HSEL & HTRANS[1] & HREADY;
   // Configuration is frozen while the engine runs; IE and DONE W1C stay writable.
   assign cfg_we    = wr_q & ~busy;

   // Capture the address phase so the following data phase knows what to do.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_q <= 1'b0;
         rd_q <= 1'b0;
         a    <= 4'h0;
      end else begin
         wr_q <= xfer & HWRITE;
         rd_q <= xfer & ~HWRITE;
         if (xfer) a <= HADDR[5:2];
      end
   end

   // Data-phase register writes, GO pulse generation, DONE sticky bit and IRQ.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         saddr  <= 32'h0;
         daddr  <= 32'h0;
         ssize  <= 3'b010;
         dsize  <= 3'b010;
         sinc   <= 3'h0;
         dinc   <= 3'h0;
         bsize  <= 8'h0;
         bcount <= 16'h0;
         wfi    <= 1'b0;
         irqsrc <= 3'h0;
         icra   <= 32'h0;
         icrv   <= 32'h0;
         ie     <= 1'b0;
         done_r <= 1'b0;
         start  <= 1'b0;
         irq    <= 1'b0;
      end else begin
         // A GO while busy is dropped rather than queued.
         start <= cfg_we & (a == A_CTRL) & HWDATA[0];
         // Completion set takes priority over a simultaneous W1C.
         done_r <= done | (done_r & ~(wr_q & (a == A_STATUS) & HWDATA[1]));
         irq    <= done_r & ie;
         if (wr_q && a == A_CTRL) ie <= HWDATA[8];
         if (cfg_we) begin
            case (a)
               A_CTRL: begin
                  wfi    <= HWDATA[1];
                  irqsrc <= HWDATA[4:2];
               end
               A_SADDR:  saddr  <= HWDATA;
               A_DADDR:  daddr  <= HWDATA;
               A_SIZE: begin
                  ssize <= HWDATA[2:0];
                  dsize <= HWDATA[6:4];
               end
               A_INC: begin
                  sinc <= HWDATA[2:0];
                  dinc <= HWDATA[6:4];
               end
               A_BSIZE:  bsize  <= HWDATA[7:0];
               A_BCOUNT: bcount <= HWDATA[15:0];
               A_ICRA:   icra   <= HWDATA;
               A_ICRV:   icrv   <= HWDATA;
               default: ;
            endcase
         end
      end
   end

   // Read mux: only drives data during a read data phase; GO and unused bits read 0.
   always_comb begin
      HRDATA = 32'h0;
      if (rd_q) begin
         case (a)
            A_CTRL:   HRDATA = {23'h0, ie, 3'h0, irqsrc, wfi, 1'b0};
            A_STATUS: HRDATA = {30'h0, done_r, busy};
            A_SADDR:  HRDATA = saddr;
            A_DADDR:  HRDATA = daddr;
            A_SIZE:   HRDATA = {25'h0, dsize, 1'b0, ssize};
            A_INC:    HRDATA = {25'h0, dinc, 1'b0, sinc};
            A_BSIZE:  HRDATA = {24'h0, bsize};
            A_BCOUNT: HRDATA = {16'h0, bcount};
            A_ICRA:   HRDATA = icra;
            A_ICRV:   HRDATA = icrv;
            default:  HRDATA = 32'h0;
         endcase
      end
   end

endmodule
